i2c_target: RTL and testbench



---
 rtl/i2c_target.sv | 155 +++++++++++++++
 tb/tb_i2c_target.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target: decodes START/STOP and a 7-bit address, then serves an 8-bit register
// space through a pointer byte. Open-drain SDA only; SCL is never stretched.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h2A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       rd_req,
  output logic       busy
);

  typedef enum logic [3:0] {IDLE, ADDR, ACK_A, PTR, WR, ACK_W, RD, MACK, IGNORE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_prev, sda_prev;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_cond, stop_cond;
  logic [7:0]             shift, pointer, rx_byte;
  logic [2:0]             bit_cnt;
  logic                   rw, ack_on;

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_prev;
  assign scl_fall   = ~scl_s & scl_prev;
  assign start_cond = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_cond  = scl_s & scl_prev & ~sda_prev & sda_s;
  assign rx_byte    = {shift[6:0], sda_s};
  assign rd_addr    = pointer;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
      sda_oe   <= 1'b0;
      wr_en    <= 1'b0;
      rd_req   <= 1'b0;
      busy     <= 1'b0;
      wr_addr  <= 8'h00;
      wr_data  <= 8'h00;
      pointer  <= 8'h00;
      shift    <= 8'h00;
      bit_cnt  <= 3'd0;
      rw       <= 1'b0;
      ack_on   <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_prev <= scl_s;
      sda_prev <= sda_s;
      wr_en    <= 1'b0;
      rd_req   <= 1'b0;
      if (start_cond) begin
        state   <= ADDR;
        bit_cnt <= 3'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        ack_on  <= 1'b0;
      end else if (stop_cond) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        ack_on <= 1'b0;
      end else if (rd_req) begin
        // rd_addr has been stable for a clock, so a registered register file is also valid here
        shift  <= rd_data;
        sda_oe <= ~rd_data[7];
      end else begin
        case (state)
          ADDR, PTR, WR: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state == ADDR) begin
                  rw    <= rx_byte[0];
                  state <= (rx_byte[7:1] == DEV_ADDR && rx_byte[7:1] != 7'd0) ? ACK_A : IGNORE;
                end else if (state == PTR) begin
                  pointer <= rx_byte;
                  state   <= ACK_W;
                end else begin
                  wr_en   <= 1'b1;
                  wr_addr <= pointer;
                  wr_data <= rx_byte;
                  pointer <= pointer + 8'd1;
                  state   <= ACK_W;
                end
              end
            end
          end
          ACK_A, ACK_W: begin
            // first falling edge starts the ACK slot, the second one ends it
            if (scl_fall) begin
              if (!ack_on) begin
                ack_on <= 1'b1;
                sda_oe <= 1'b1;
                if (state == ACK_A) busy <= 1'b1;
              end else begin
                ack_on  <= 1'b0;
                bit_cnt <= 3'd0;
                if (state == ACK_A && rw) begin
                  state  <= RD;
                  rd_req <= 1'b1;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= (state == ACK_A) ? PTR : WR;
                end
              end
            end
          end
          RD: begin
            if (scl_fall) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                sda_oe  <= 1'b0;
                pointer <= pointer + 8'd1;
                state   <= MACK;
                ack_on  <= 1'b0;
              end else begin
                shift  <= {shift[6:0], 1'b0};
                sda_oe <= ~shift[6];
              end
            end
          end
          MACK: begin
            if (scl_rise) begin
              if (sda_s) state <= IGNORE;
              else       ack_on <= 1'b1;
            end else if (scl_fall && ack_on) begin
              ack_on  <= 1'b0;
              bit_cnt <= 3'd0;
              state   <= RD;
              rd_req  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C controller, register file behind the target,
// and a transaction-level memory/pointer model for expected data.
module tb_i2c_target;
  localparam int Q = 12;  // clocks per quarter SCL period

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_oe, wr_en, rd_req, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

  i2c_target dut (
    .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_req(rd_req), .busy(busy)
  );

  always #5 clk = ~clk;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  logic [7:0] regs [256];
  assign rd_data = regs[rd_addr];

  logic [7:0] wq_addr[$], wq_data[$];
  int         rd_req_cnt = 0;
  logic [7:0] last_rd_addr = 8'h00;
  logic       oe_seen = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
    if (rd_req) begin
      rd_req_cnt++;
      last_rd_addr = rd_addr;
    end
    if (sda_oe) oe_seen = 1'b1;
  end

  int         tests = 0, fails = 0;
  logic [7:0] model_mem [256];
  logic [7:0] model_ptr;
  logic [7:0] wdata[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_cycle(input logic v, output logic s);
    sda_m = v;   #(Q*10);
    scl_m = 1'b1; #(Q*10);
    s = sda_in;   #(Q*10);
    scl_m = 1'b0; #(Q*10);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #(Q*10);
    scl_m = 1'b1; #(Q*10);
    sda_m = 1'b0; #(Q*10);
    scl_m = 1'b0; #(Q*10);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #(Q*10);
    scl_m = 1'b1; #(Q*10);
    sda_m = 1'b1; #(Q*10);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], d);
    bit_cycle(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      b[i] = s;
    end
    bit_cycle(nack, s);
  endtask

  // Write transaction: pointer byte then the bytes in wdata
  task automatic do_write(input logic [7:0] ptr, input string tag);
    logic ack;
    int   base;
    base = wq_addr.size();
    i2c_start();
    send_byte(8'h54, ack);
    check({tag, "_addr_ack"}, ack, 0);
    check({tag, "_busy_on"}, busy, 1);
    send_byte(ptr, ack);
    check({tag, "_ptr_ack"}, ack, 0);
    foreach (wdata[i]) begin
      send_byte(wdata[i], ack);
      check({tag, "_data_ack"}, ack, 0);
    end
    i2c_stop();
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_wr_count"}, wq_addr.size() - base, wdata.size());
    model_ptr = ptr;
    foreach (wdata[i]) begin
      if (base + i < wq_addr.size()) begin
        check({tag, "_wr_addr"}, wq_addr[base+i], model_ptr);
        check({tag, "_wr_data"}, wq_data[base+i], wdata[i]);
      end
      model_mem[model_ptr] = wdata[i];
      model_ptr = model_ptr + 8'd1;
    end
    $display("[TB] write %s ptr=%02h bytes=%0d", tag, ptr, wdata.size());
  endtask

  // Read transaction of n bytes from the current pointer, NACK on the last
  task automatic do_read(input int n, input string tag);
    logic       ack;
    logic [7:0] b;
    int         base;
    base = rd_req_cnt;
    i2c_start();
    send_byte(8'h55, ack);
    check({tag, "_addr_ack"}, ack, 0);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, b);
      check({tag, "_rd_data"}, b, model_mem[model_ptr]);
      model_ptr = model_ptr + 8'd1;
    end
    i2c_stop();
    check({tag, "_rd_req_count"}, rd_req_cnt - base, n);
    check({tag, "_sda_released"}, sda_oe, 0);
    $display("[TB] read %s bytes=%0d", tag, n);
  endtask

  initial begin
    logic       ack;
    logic [7:0] b, p;
    int         n, wbase, rbase;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    model_ptr = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    $display("[TB] reset state checked");

    // 1: write two bytes at 0x10
    wdata = {8'hA5, 8'h5A};
    do_write(8'h10, "t1");

    // 2: pointer-only write, then read two bytes back
    wdata = {};
    do_write(8'h10, "t2_ptr");
    do_read(2, "t2");

    // 3: pointer then repeated START into a single-byte read
    wdata = {8'($urandom)};
    do_write(8'h20, "t3_fill");
    wbase = wq_addr.size();
    rbase = rd_req_cnt;
    i2c_start();
    send_byte(8'h54, ack);
    check("t3_addr_ack", ack, 0);
    send_byte(8'h20, ack);
    check("t3_ptr_ack", ack, 0);
    i2c_start();
    send_byte(8'h55, ack);
    check("t3_raddr_ack", ack, 0);
    recv_byte(1'b1, b);
    i2c_stop();
    model_ptr = 8'h21;
    check("t3_rd_data", b, model_mem[8'h20]);
    check("t3_rd_addr", last_rd_addr, 8'h20);
    check("t3_no_wr", wq_addr.size() - wbase, 0);
    check("t3_rd_req_count", rd_req_cnt - rbase, 1);
    $display("[TB] combined read ptr=20 data=%02h", b);

    // 4: wrong address gets no ACK and the target stays silent
    wbase = wq_addr.size();
    rbase = rd_req_cnt;
    oe_seen = 1'b0;
    i2c_start();
    send_byte(8'h56, ack);
    check("t4_addr_nack", ack, 1);
    send_byte(8'h11, ack);
    check("t4_data_nack", ack, 1);
    i2c_stop();
    check("t4_oe_quiet", oe_seen, 0);
    check("t4_no_wr", wq_addr.size() - wbase, 0);
    check("t4_no_rd", rd_req_cnt - rbase, 0);
    check("t4_busy", busy, 0);
    $display("[TB] mismatched address 2B ignored");

    // 5: pointer wraps from FF to 00
    wdata = {8'($urandom), 8'($urandom)};
    do_write(8'hFF, "t5");

    // 6: reset while the target pulls SDA low for a data bit
    wdata = {8'h3C};
    do_write(8'h40, "t6_fill");
    wdata = {};
    do_write(8'h40, "t6_ptr");
    i2c_start();
    send_byte(8'h55, ack);
    check("t6_addr_ack", ack, 0);
    check("t6_driving", sda_oe, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("t6_oe_after_reset", sda_oe, 0);
    check("t6_busy_after_reset", busy, 0);
    check("t6_ptr_after_reset", rd_addr, 0);
    model_ptr = 8'h00;
    i2c_stop();
    $display("[TB] reset mid-read");
    wdata = {8'($urandom)};
    do_write(8'h77, "t6_after");

    // random write/readback transactions
    for (int k = 0; k < 5; k++) begin
      p = 8'($urandom);
      n = $urandom_range(1, 3);
      wdata = {};
      for (int j = 0; j < n; j++) wdata.push_back(8'($urandom));
      do_write(p, "rnd_wr");
      wdata = {};
      do_write(p, "rnd_ptr");
      do_read(n, "rnd_rd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
